// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared definitions for the four-source round-robin FIFO drain scheduler.
package fifo_rr_arbiter_pkg;

    localparam int SRC_N = 4;
    localparam int SRC_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_PAUSE  = 2'd2
    } arb_state_t;

    // Source index reached by stepping 'off' places forward from 'base', wrapping.
    function automatic logic [SRC_W-1:0] rr_idx(input logic [SRC_W-1:0] base,
                                                input int unsigned      off);
        return base + SRC_W'(off);
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick4.sv
// Purpose: one-hot round-robin pick among four requesters, searching from last+1.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
module rr_pick4
    import fifo_rr_arbiter_pkg::*;
(
    input  logic [SRC_N-1:0] req,
    input  logic [SRC_W-1:0] last,
    output logic [SRC_N-1:0] gnt,
    output logic [SRC_W-1:0] gnt_idx,
    output logic             any
);

    // Walk from the farthest candidate to the nearest so the nearest wins;
    // the previous winner itself is the last resort.
    always_comb begin
        gnt_idx = last;
        for (int k = SRC_N; k >= 1; k--) begin
            if (req[rr_idx(last, k)]) begin
                gnt_idx = rr_idx(last, k);
            end
        end
        any = |req;
        gnt = any ? (SRC_N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Purpose: drain four source fifo16 queues round-robin into one tagged sink fifo16.
// Latency: fixed 2 cycles pop->push, one word per cycle.
// Backpressure: pops stop on sink almost_full/full, resume only after sink reaches almost_empty/empty.
module fifo_rr_arbiter
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_SRC    = SRC_N
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [NUM_SRC-1:0]            in_empty,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] in_data,
    output logic [NUM_SRC-1:0]            in_pop,
    input  logic                          out_full,
    input  logic                          out_almost_full,
    input  logic                          out_almost_empty,
    input  logic                          out_empty,
    output logic                          out_push,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [SRC_W-1:0]              out_src,
    output logic [1:0]                    state,
    output logic                          idle
);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [SRC_W-1:0]        r_last_grant;
    logic                    r_vld1;
    logic [SRC_W-1:0]        r_sel1;
    logic                    r_out_push;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic [SRC_W-1:0]        r_out_src;

    logic [NUM_SRC-1:0]      w_req;
    logic [NUM_SRC-1:0]      w_gnt;
    logic [SRC_W-1:0]        w_gnt_idx;
    logic                    w_any;
    logic                    w_sink_hold;
    logic                    w_pop_ok;
    logic [DATA_WIDTH-1:0]   w_sel_word;

    assign w_req       = ~in_empty;
    assign w_sink_hold = out_almost_full | out_full;

    rr_pick4 u_pick (
        .req     (w_req),
        .last    (r_last_grant),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    // Gating on almost_full in the same cycle bounds in-flight words to two,
    // which is exactly the headroom left in the sink at count 14.
    assign w_pop_ok = (r_state == ST_ACTIVE) & enable & ~w_sink_hold & w_any;
    assign in_pop   = w_pop_ok ? w_gnt : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable & w_any & ~w_sink_hold) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_sink_hold) begin
                    w_state_nxt = ST_PAUSE;
                end else if (~enable | ~w_any) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PAUSE: begin
                if (out_almost_empty | out_empty) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Source buf_out is registered, so the popped word is selected a cycle after the pop.
    always_comb begin
        w_sel_word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_sel1 == SRC_W'(i)) begin
                w_sel_word = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= SRC_W'(NUM_SRC - 1);
            r_vld1       <= 1'b0;
            r_sel1       <= '0;
            r_out_push   <= 1'b0;
            r_out_data   <= '0;
            r_out_src    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_vld1     <= w_pop_ok;
            r_sel1     <= w_gnt_idx;
            r_out_push <= r_vld1;
            if (w_pop_ok) begin
                r_last_grant <= w_gnt_idx;
            end
            if (r_vld1) begin
                r_out_data <= w_sel_word;
                r_out_src  <= r_sel1;
            end
        end
    end

    assign out_push = r_out_push;
    assign out_data = r_out_data;
    assign out_src  = r_out_src;
    assign state    = r_state;
    assign idle     = (r_state == ST_IDLE) & ~r_vld1 & ~r_out_push;

    a_no_push_into_full: assert property (@(posedge clk) disable iff (rst) !(r_out_push && out_full));

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed and randomized bench for fifo_rr_arbiter against a queue-based model of sources, sink and scheduler.
module tb_fifo_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  in_empty;
    logic [15:0] in_data;
    logic [3:0]  in_pop;
    logic        out_full, out_almost_full, out_almost_empty, out_empty;
    logic        out_push;
    logic [3:0]  out_data;
    logic [1:0]  out_src;
    logic [1:0]  state;
    logic        idle;

    always #5 clk = ~clk;

    fifo_rr_arbiter #(.DATA_WIDTH(4), .NUM_SRC(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .in_empty         (in_empty),
        .in_data          (in_data),
        .in_pop           (in_pop),
        .out_full         (out_full),
        .out_almost_full  (out_almost_full),
        .out_almost_empty (out_almost_empty),
        .out_empty        (out_empty),
        .out_push         (out_push),
        .out_data         (out_data),
        .out_src          (out_src),
        .state            (state),
        .idle             (idle)
    );

    int n_chk = 0;
    int n_err = 0;

    // Environment: source queues with registered buf_out, and a counting sink.
    logic [3:0] sq [4][$];
    logic [3:0] src_out [4];
    int         sk_cnt;
    bit         sk_rd;
    bit         en;

    // Reference scheduler: state 0/1/2, last grant, and the two-deep delivery line.
    int         mstate, mlast;
    bit         m_s1v, m_push;
    int         m_s1s, m_src;
    logic [3:0] m_s1d, m_data;

    // Observations of the most recent cycle.
    logic [3:0] s_pop;
    bit         s_push, s_idle;
    logic [1:0] s_state;
    int         s_cnt;
    int         cyc, n_push, n_pops, first_pop, first_push, last_push;
    logic [5:0] got [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        mstate = 0; mlast = 3; m_s1v = 0; m_push = 0; m_src = 0; m_data = 4'd0; m_s1s = 0; m_s1d = 4'd0;
    endtask

    task automatic clear_obs();
        n_push = 0; n_pops = 0; first_pop = -1; first_push = -1; last_push = -1;
        got.delete();
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            in_empty[i]         = (sq[i].size() == 0);
            in_data[i*4 +: 4]   = src_out[i];
        end
        out_full         = (sk_cnt == 16);
        out_almost_full  = (sk_cnt == 14);
        out_almost_empty = (sk_cnt == 3);
        out_empty        = (sk_cnt == 0);
        enable           = en;
    endtask

    task automatic cycle();
        bit         any, af, fu, ae, em, pop_ok;
        int         g, nst, cb, idx;
        logic [3:0] e_pop, word;
        @(negedge clk);
        drive();
        #1;
        any = 0;
        for (int i = 0; i < 4; i++) if (sq[i].size() > 0) any = 1;
        af = (sk_cnt == 14); fu = (sk_cnt == 16); ae = (sk_cnt == 3); em = (sk_cnt == 0);
        pop_ok = (mstate == 1) && en && !af && !fu && any;
        g = -1; word = 4'd0; e_pop = 4'd0;
        if (pop_ok) begin
            for (int k = 1; k <= 4; k++) begin
                idx = (mlast + k) % 4;
                if (g < 0 && sq[idx].size() > 0) g = idx;
            end
            e_pop = 4'b0001 << g;
            word  = sq[g][0];
        end
        chk("in_pop", in_pop, e_pop);
        chk("out_push", out_push, m_push);
        chk("out_data", out_data, m_data);
        chk("out_src", out_src, m_src);
        chk("state", state, mstate);
        chk("idle", idle, (mstate == 0 && !m_s1v && !m_push));
        chk("push_while_full", out_push & out_full, 0);
        s_pop = in_pop; s_push = out_push; s_state = state; s_idle = idle; s_cnt = sk_cnt;
        cyc++;
        if (in_pop != 4'd0) begin
            n_pops++;
            if (first_pop < 0) first_pop = cyc;
        end
        if (out_push) begin
            n_push++;
            if (first_push < 0) first_push = cyc;
            last_push = cyc;
            got.push_back({out_src, out_data});
        end
        @(posedge clk);
        cb = sk_cnt;
        if (s_push && cb < 16) sk_cnt++;
        if (sk_rd && cb > 0) sk_cnt--;
        for (int i = 0; i < 4; i++) begin
            if (s_pop[i] && sq[i].size() > 0) src_out[i] = sq[i].pop_front();
        end
        if (rst) begin
            model_reset();
        end else begin
            nst = mstate;
            case (mstate)
                0: if (en && any && !af && !fu) nst = 1;
                1: if (af || fu) nst = 2; else if (!en || !any) nst = 0;
                default: if (ae || em) nst = 0;
            endcase
            m_push = m_s1v;
            if (m_s1v) begin
                m_src  = m_s1s;
                m_data = m_s1d;
            end
            m_s1v = pop_ok;
            if (pop_ok) begin
                m_s1s = g; m_s1d = word; mlast = g;
            end
            mstate = nst;
        end
    endtask

    task automatic wait_quiet();
        bit ok;
        ok = 0;
        for (int t = 0; t < 200 && !ok; t++) begin
            cycle();
            ok = s_idle && sk_cnt == 0 && sq[0].size() == 0 && sq[1].size() == 0 &&
                 sq[2].size() == 0 && sq[3].size() == 0;
        end
        chk("drain_timeout", ok, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] e6;
        logic [3:0] w3 [$];
        bit hit14, saw_pause, saw_idle, saw_act;
        int n_after;

        rst = 1; en = 0; sk_rd = 0; sk_cnt = 0; cyc = 0;
        for (int i = 0; i < 4; i++) src_out[i] = 4'd0;
        model_reset(); clear_obs(); drive();
        #2;
        chk("rst_push", out_push, 0);
        chk("rst_data", out_data, 0);
        chk("rst_src", out_src, 0);
        chk("rst_state", state, 0);
        chk("rst_idle", idle, 1);
        chk("rst_pop", in_pop, 0);
        cycle(); cycle();
        rst = 0;

        // Preloaded round-robin burst into a draining sink.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) sq[i].push_back(4'(4*i + j + 1));
        en = 1; sk_rd = 1; clear_obs();
        repeat (24) cycle();
        chk("t1_count", got.size(), 16);
        for (int k = 0; k < got.size(); k++) begin
            e6 = {2'(k % 4), 4'((k % 4) * 4 + k / 4 + 1)};
            chk("t1_word", got[k], e6);
        end
        chk("t1_latency", first_push - first_pop, 2);
        chk("t1_burst", last_push - first_push, 15);

        // Sole requester may be granted back to back.
        clear_obs(); w3.delete();
        for (int j = 0; j < 3; j++) begin
            w3.push_back(4'($urandom_range(0, 15)));
            sq[2].push_back(w3[j]);
        end
        for (int t = 0; t < 20 && first_pop < 0; t++) cycle();
        chk("t2_pop0", s_pop, 4'b0100);
        cycle(); chk("t2_pop1", s_pop, 4'b0100);
        cycle(); chk("t2_pop2", s_pop, 4'b0100);
        repeat (3) cycle();
        chk("t2_state", s_state, 0);
        chk("t2_idle", s_idle, 1);
        chk("t2_count", got.size(), 3);
        for (int k = 0; k < got.size(); k++) chk("t2_word", got[k], {2'd2, w3[k]});

        // Fill the sink to almost_full, pause, then drain through almost_empty.
        clear_obs(); sk_rd = 0; hit14 = 0; saw_pause = 0; n_after = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 6; j++) sq[i].push_back(4'($urandom_range(0, 15)));
        for (int t = 0; t < 60; t++) begin
            cycle();
            if (s_cnt == 14 && !hit14) begin
                hit14 = 1;
                chk("t3_gate", s_pop, 0);
            end
            if (hit14 && s_push) n_after++;
            if (s_state == 2'd2) saw_pause = 1;
        end
        chk("t3_hit14", hit14, 1);
        chk("t3_pause", saw_pause, 1);
        chk("t3_after", n_after <= 2, 1);
        chk("t3_sink_cnt", sk_cnt, 16);
        sk_rd = 1; saw_idle = 0; saw_act = 0;
        for (int t = 0; t < 60 && !saw_act; t++) begin
            cycle();
            if (s_state == 2'd0) saw_idle = 1;
            if (saw_idle && s_state == 2'd1) saw_act = 1;
        end
        chk("t3_idle", saw_idle, 1);
        chk("t3_resume", saw_act, 1);
        wait_quiet();

        // Enable dropped after two pops; in-flight words still land.
        clear_obs();
        for (int j = 0; j < 3; j++) begin
            sq[0].push_back(4'($urandom_range(0, 15)));
            sq[1].push_back(4'($urandom_range(0, 15)));
        end
        en = 1;
        for (int t = 0; t < 20 && n_pops < 2; t++) cycle();
        en = 0;
        repeat (8) cycle();
        chk("t4_pops", n_pops, 2);
        chk("t4_push", n_push, 2);
        chk("t4_idle", s_idle, 1);
        en = 1;
        wait_quiet();
        chk("t4_total", n_push, 6);

        // Asynchronous reset with one word in flight.
        clear_obs();
        sq[1].push_back(4'($urandom_range(0, 15)));
        for (int t = 0; t < 20 && n_pops < 1; t++) cycle();
        chk("t5_pop", s_pop, 4'b0010);
        cycle();
        #2; rst = 1; model_reset();
        #1;
        chk("t5_push", out_push, 0);
        chk("t5_state", state, 0);
        chk("t5_idle", idle, 1);
        chk("t5_src", out_src, 0);
        chk("t5_data", out_data, 0);
        repeat (2) cycle();
        rst = 0; clear_obs();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 2; j++) sq[i].push_back(4'($urandom_range(0, 15)));
        for (int t = 0; t < 20 && n_pops < 1; t++) cycle();
        chk("t5_first", s_pop, 4'b0001);
        wait_quiet();

        // All sources empty, then source 3 wakes the scheduler.
        repeat (5) cycle();
        chk("t6_idle_state", s_state, 0);
        chk("t6_idle_pop", s_pop, 0);
        sq[3].push_back(4'($urandom_range(0, 15)));
        cycle();
        chk("t6_s0", s_state, 0);
        chk("t6_p0", s_pop, 0);
        cycle();
        chk("t6_s1", s_state, 1);
        chk("t6_p1", s_pop, 4'b1000);
        wait_quiet();

        // Random traffic, enable toggling, intermittent sink reads.
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                int i;
                i = $urandom_range(0, 3);
                if (sq[i].size() < 16) sq[i].push_back(4'($urandom_range(0, 15)));
            end
            sk_rd = ($urandom_range(0, 3) != 0);
            en    = ($urandom_range(0, 9) != 0);
            cycle();
        end
        en = 1; sk_rd = 1;
        wait_quiet();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
Read-side scheduler that drains four fifo16 source queues into one downstream fifo16 sink.
- Each cycle it grants one non-empty source in round-robin order, pulses that source's rd_en and captures the popped word.
- It pushes the word into the sink together with a 2-bit source tag.
- It throttles on the sink's almost_full/full flags, with hysteresis released by almost_empty/empty.
- Sits between the per-lane input FIFOs and the shared output FIFO.

Parameters:
DATA_WIDTH, 4, word width; matches source and sink fifo16 DATA_WIDTH.
NUM_SRC, 4, number of source FIFOs; fixed at 4 in this revision, 2-bit tag.

Ports:
clk  input  1  clock, all state on rising edge.
rst  input  1  asynchronous reset, active-high.
enable  input  1  arbitration enable; 0 stops new pops.
in_empty  input  4  buf_empty of source FIFO i (bit i).
in_data  input  4*DATA_WIDTH  buf_out of source i at bits [i*DATA_WIDTH +: DATA_WIDTH].
in_pop  output  4  rd_en to source i; one-hot or zero.
out_full  input  1  sink buf_full.
out_almost_full  input  1  sink almost_full (count == 14).
out_almost_empty  input  1  sink almost_empty (count == 3).
out_empty  input  1  sink buf_empty.
out_push  output  1  wr_en to sink.
out_data  output  DATA_WIDTH  buf_in to sink.
out_src  output  2  source index of out_data.
state  output  2  FSM state: IDLE=0, ACTIVE=1, PAUSE=2.
idle  output  1  state==IDLE and no word in flight.

Behaviour:
- Reset (async, any time): state=IDLE, rr pointer last_grant=3 (so source 0 has first priority), pipeline valid bits=0, out_push=0, out_data=0, out_src=0, in_pop=0, idle=1. In-flight words are discarded.
- FSM:
  - IDLE->ACTIVE when enable & |~in_empty & ~out_almost_full & ~out_full.
  - ACTIVE->PAUSE when out_almost_full | out_full (takes priority).
  - ACTIVE->IDLE when ~enable | &in_empty.
  - PAUSE->IDLE when out_almost_empty | out_empty. Never PAUSE->ACTIVE directly.
- Pop rule (combinational from registered state and current inputs): in_pop nonzero only if state==ACTIVE & enable & ~out_almost_full & ~out_full & some in_empty bit is 0.
- Grant: first non-empty index searched circularly from last_grant+1. last_grant updates to the granted index on the same edge. No grant means last_grant holds.
- A source may be granted on consecutive cycles only if it is the sole non-empty source.
- Never pop an empty source; the source FIFO ignores such a rd_en and a phantom word would be pushed.
- Latency (fifo16 buf_out is registered):
  - pop in cycle n; stage-1 valid/sel registered at end of n.
  - source buf_out valid in n+1; at end of n+1, out_data<=in_data[sel1], out_src<=sel1, out_push<=valid1.
  - Sink write happens in cycle n+2. Fixed latency 2, throughput 1 word/cycle.
- Backpressure proof: pops gated by out_almost_full the same cycle, at most 2 words in flight, count 14+2=16, so the sink never overflows. out_push must never assert while out_full=1 (assertion).
- Hysteresis: sink flags are equality flags; the count moves by at most 1 per cycle, so draining from 14 always passes through 3.
- enable deasserted mid-burst: pops stop that cycle, in-flight words still delivered; idle rises after the pipeline drains.
- out_push=0 holds out_data/out_src at their last values.

Decomposition:
- Shared include fifo_defs.vh: state encodings ST_IDLE/ST_ACTIVE/ST_PAUSE, NUM_SRC=4, SRC_W=2.
- Sub-module rr_pick4 (combinational): inputs req[3:0], last[1:0]; outputs gnt[3:0] one-hot, gnt_idx[1:0], any.
- FSM, pipeline and pointer stay in fifo_rr_arbiter.

Test Plan:
- Reset then enable=1, sources 0..3 preloaded with {1,2,3,4},{5,6,7,8},{9,A,B,C},{D,E,F,0}, sink empty -> out_src sequence 0,1,2,3,0,1,... and out_data 1,5,9,D,2,6,...; first out_push 2 cycles after first in_pop; 16 consecutive push cycles.
- Only source 2 non-empty with 3 words -> in_pop=4'b0100 for 3 consecutive cycles; out_src=2 x3; then state=IDLE, idle=1 after 2 more cycles.
- Sink count driven to 14 -> in_pop=0 in that same cycle; state=PAUSE; at most 2 further out_push; out_full never coincides with out_push; drain sink to 3 -> IDLE then ACTIVE, pops resume from the next rr index.
- enable dropped after 2 pops with 6 words queued -> exactly 2 out_push, then idle=1; re-enable -> grant continues from last_grant+1.
- rst pulsed mid-burst with 1 word in flight -> out_push=0 immediately, state=IDLE, last_grant=3, and the next grant is source 0.
- All sources empty with enable=1 -> state stays IDLE, in_pop=0 forever; source 3 becomes non-empty -> ACTIVE next cycle, in_pop=4'b1000 the cycle after.
